double_buffer_swap_ctrl: RTL and testbench

Controller for the frame double buffer between the HDMI capture side (writer) and the LED-matrix output side (reader). Tracks which of the two banks each side owns and flips them only at safe frame boundaries. Generates the one-cycle swap pulse for the info buffer and the pixel banks, plus a read-start pulse to the matrix scan logic. Counts frames overwritten before they could be displayed.

---
 rtl/double_buffer_swap_ctrl.sv | 140 ++++++++++++++
 tb/tb_double_buffer_swap_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/double_buffer_swap_ctrl.sv
// Frame double-buffer controller: owns the writer/reader bank split and flips it only at frame boundaries.
// Emits swap and read-start strobes and counts frames overwritten before display.
module double_buffer_swap_ctrl #(
    parameter int GUARD_CYCLES = 2,
    parameter bit REPEAT_LAST  = 1'b1,
    parameter int DROP_CNT_W   = 8
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_flush,
    input  logic                  I_write_done,
    input  logic                  I_frame_ok,
    input  logic                  I_read_done,
    output logic                  O_write_bank,
    output logic                  O_read_bank,
    output logic                  O_swap,
    output logic                  O_read_start,
    output logic                  O_read_valid,
    output logic                  O_pending,
    output logic [DROP_CNT_W-1:0] O_drop_count
);

    // state   | meaning
    // EMPTY   | reader has no frame
    // SWAP    | banks flip this cycle
    // GUARD   | settle delay after the flip
    // START   | reader kicked off
    // READING | reader scanning the read bank
    typedef enum logic [2:0] {
        EMPTY   = 3'd0,
        SWAP    = 3'd1,
        GUARD   = 3'd2,
        START   = 3'd3,
        READING = 3'd4
    } state_t;

    localparam int GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

    state_t                state, state_next;
    logic [GW-1:0]         guard_cnt, guard_next;
    logic                  write_bank, bank_next;
    logic                  pending, pending_next;
    logic                  displayed, displayed_next;
    logic [DROP_CNT_W-1:0] drop_count, drop_next;
    logic                  accepted;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state      <= EMPTY;
            guard_cnt  <= '0;
            write_bank <= 1'b0;
            pending    <= 1'b0;
            displayed  <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_next;
            guard_cnt  <= guard_next;
            write_bank <= bank_next;
            pending    <= pending_next;
            displayed  <= displayed_next;
            drop_count <= drop_next;
        end
    end

    always_comb begin
        accepted       = I_write_done & I_frame_ok;
        state_next     = state;
        guard_next     = guard_cnt;
        bank_next      = write_bank;
        pending_next   = pending;
        displayed_next = displayed;
        drop_next      = drop_count;

        // A pending frame is consumed by the swap in progress, so a new one during SWAP is not a drop.
        if (accepted && state != EMPTY) begin
            pending_next = 1'b1;
            if (pending && state != SWAP && drop_count != '1)
                drop_next = drop_count + DROP_CNT_W'(1);
        end

        case (state)
            EMPTY: begin
                if (accepted)
                    state_next = SWAP;
            end
            SWAP: begin
                bank_next = ~write_bank;
                if (!accepted)
                    pending_next = 1'b0;
                if (GUARD_CYCLES == 0) begin
                    state_next = START;
                end else begin
                    state_next = GUARD;
                    guard_next = GW'(GUARD_CYCLES);
                end
            end
            GUARD: begin
                guard_next = guard_cnt - GW'(1);
                if (guard_cnt == GW'(1))
                    state_next = START;
            end
            START: begin
                displayed_next = 1'b1;
                state_next     = READING;
            end
            READING: begin
                if (I_read_done) begin
                    if (pending || accepted) begin
                        state_next = SWAP;
                    end else if (REPEAT_LAST) begin
                        state_next = START;
                    end else begin
                        state_next     = EMPTY;
                        displayed_next = 1'b0;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase

        if (I_flush) begin
            state_next     = EMPTY;
            guard_next     = '0;
            bank_next      = write_bank;
            pending_next   = 1'b0;
            displayed_next = 1'b0;
            drop_next      = drop_count;
        end
    end

    assign O_write_bank = write_bank;
    assign O_read_bank  = ~write_bank;
    assign O_swap       = (state == SWAP);
    assign O_read_start = (state == START);
    assign O_read_valid = (state == START) || (state == READING) ||
                          (((state == SWAP) || (state == GUARD)) && displayed);
    assign O_pending    = pending;
    assign O_drop_count = drop_count;

endmodule

// File: tb/tb_double_buffer_swap_ctrl.sv
// Directed bench for double_buffer_swap_ctrl: one instance with guard 2 / repeat,
// one with guard 0 / go-empty / 2-bit drop counter, both on shared stimulus.
module tb_double_buffer_swap_ctrl;

    logic clk = 1'b0;
    logic rst, flush, write_done, frame_ok, read_done;

    logic       wb_a, rb_a, swap_a, start_a, valid_a, pend_a;
    logic [7:0] drop_a;
    logic       wb_b, rb_b, swap_b, start_b, valid_b, pend_b;
    logic [1:0] drop_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    double_buffer_swap_ctrl #(.GUARD_CYCLES(2), .REPEAT_LAST(1'b1), .DROP_CNT_W(8)) dut_a (
        .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_write_done(write_done),
        .I_frame_ok(frame_ok), .I_read_done(read_done),
        .O_write_bank(wb_a), .O_read_bank(rb_a), .O_swap(swap_a), .O_read_start(start_a),
        .O_read_valid(valid_a), .O_pending(pend_a), .O_drop_count(drop_a)
    );

    double_buffer_swap_ctrl #(.GUARD_CYCLES(0), .REPEAT_LAST(1'b0), .DROP_CNT_W(2)) dut_b (
        .I_clk(clk), .I_rst(rst), .I_flush(flush), .I_write_done(write_done),
        .I_frame_ok(frame_ok), .I_read_done(read_done),
        .O_write_bank(wb_b), .O_read_bank(rb_b), .O_swap(swap_b), .O_read_start(start_b),
        .O_read_valid(valid_b), .O_pending(pend_b), .O_drop_count(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic wd, input logic ok, input logic rd, input logic fl);
        write_done = wd;
        frame_ok   = ok;
        read_done  = rd;
        flush      = fl;
        step();
        write_done = 1'b0;
        frame_ok   = 1'b0;
        read_done  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic chk_a_reset(input string tag);
        chk({tag, "_wb"},    32'(wb_a),    0);
        chk({tag, "_rb"},    32'(rb_a),    1);
        chk({tag, "_swap"},  32'(swap_a),  0);
        chk({tag, "_start"}, 32'(start_a), 0);
        chk({tag, "_valid"}, 32'(valid_a), 0);
        chk({tag, "_pend"},  32'(pend_a),  0);
        chk({tag, "_drop"},  32'(drop_a),  0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; write_done = 1'b0; frame_ok = 1'b0; read_done = 1'b0;
        do_reset();
        chk_a_reset("rst");

        // unqualified frame in EMPTY
        pulse(1, 0, 0, 0);
        chk("bad_empty_swap", 32'(swap_a), 0);
        chk("bad_empty_pend", 32'(pend_a), 0);
        step();
        chk("bad_empty_swap2", 32'(swap_a), 0);

        // first frame: swap t+1, banks t+2, start t+4
        pulse(1, 1, 0, 0);
        chk("ff_swap_t1",   32'(swap_a),  1);
        chk("ff_wb_t1",     32'(wb_a),    0);
        chk("ff_valid_t1",  32'(valid_a), 0);
        chk("ff_start_t1",  32'(start_a), 0);
        step();
        chk("ff_swap_t2",   32'(swap_a),  0);
        chk("ff_wb_t2",     32'(wb_a),    1);
        chk("ff_rb_t2",     32'(rb_a),    0);
        chk("ff_valid_t2",  32'(valid_a), 0);
        step();
        chk("ff_start_t3",  32'(start_a), 0);
        step();
        chk("ff_start_t4",  32'(start_a), 1);
        chk("ff_valid_t4",  32'(valid_a), 1);
        step();
        chk("ff_start_t5",  32'(start_a), 0);
        chk("ff_valid_t5",  32'(valid_a), 1);

        // unqualified frame in READING
        pulse(1, 0, 0, 0);
        chk("bad_rd_pend",  32'(pend_a),  0);
        chk("bad_rd_drop",  32'(drop_a),  0);
        chk("bad_rd_swap",  32'(swap_a),  0);
        chk("bad_rd_valid", 32'(valid_a), 1);

        // three frames before read_done
        pulse(1, 1, 0, 0);
        chk("drop_f1_pend", 32'(pend_a), 1);
        chk("drop_f1_cnt",  32'(drop_a), 0);
        pulse(1, 1, 0, 0);
        pulse(1, 1, 0, 0);
        chk("drop_f3_pend", 32'(pend_a), 1);
        chk("drop_f3_cnt",  32'(drop_a), 2);
        pulse(0, 0, 1, 0);
        chk("drop_swap_t1", 32'(swap_a), 1);
        step();
        chk("drop_swap_t2", 32'(swap_a),  0);
        chk("drop_pend_t2", 32'(pend_a),  0);
        chk("drop_wb_t2",   32'(wb_a),    0);
        chk("drop_valid_g", 32'(valid_a), 1);
        step();
        chk("drop_swap_t3", 32'(swap_a), 0);
        step();
        chk("drop_start_t4", 32'(start_a), 1);
        chk("drop_swap_t4",  32'(swap_a),  0);
        step();

        // accepted frame together with read_done
        pulse(1, 1, 1, 0);
        chk("sim_swap_t1", 32'(swap_a), 1);
        chk("sim_drop_t1", 32'(drop_a), 2);
        step();
        chk("sim_wb_t2",   32'(wb_a),   1);
        chk("sim_pend_t2", 32'(pend_a), 0);
        chk("sim_drop_t2", 32'(drop_a), 2);
        step();
        step();
        chk("sim_start_t4", 32'(start_a), 1);
        step();

        // redisplay
        pulse(0, 0, 1, 0);
        chk("rep_start", 32'(start_a), 1);
        chk("rep_swap",  32'(swap_a),  0);
        chk("rep_wb",    32'(wb_a),    1);
        step();
        chk("rep_start2", 32'(start_a), 0);

        // flush during GUARD
        pulse(1, 1, 0, 0);
        pulse(0, 0, 1, 0);
        chk("fl_swap", 32'(swap_a), 1);
        step();
        chk("fl_wb_guard", 32'(wb_a), 0);
        pulse(0, 0, 0, 1);
        chk("fl_valid", 32'(valid_a), 0);
        chk("fl_start", 32'(start_a), 0);
        chk("fl_wb",    32'(wb_a),    0);
        chk("fl_pend",  32'(pend_a),  0);
        chk("fl_drop",  32'(drop_a),  2);
        step();
        chk("fl_start2", 32'(start_a), 0);
        chk("fl_swap2",  32'(swap_a),  0);

        // reset in READING with drops and a pending frame
        pulse(1, 1, 0, 0);
        step(); step(); step(); step();
        chk("rr_reading", 32'(valid_a), 1);
        pulse(1, 1, 0, 0);
        chk("rr_pend", 32'(pend_a), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_a_reset("rr");

        // guard 0, go-empty, 2-bit saturating drop counter
        do_reset();
        pulse(1, 1, 0, 0);
        chk("b_swap_t1",  32'(swap_b),  1);
        step();
        chk("b_start_t2", 32'(start_b), 1);
        chk("b_valid_t2", 32'(valid_b), 1);
        chk("b_wb_t2",    32'(wb_b),    1);
        step();
        for (int i = 0; i < 4; i++) pulse(1, 1, 0, 0);
        chk("b_sat_4",  32'(drop_b), 3);
        for (int i = 0; i < 3; i++) pulse(1, 1, 0, 0);
        chk("b_sat_7",  32'(drop_b), 3);
        chk("b_pend_7", 32'(pend_b), 1);
        pulse(0, 0, 1, 0);
        chk("b_swap2",  32'(swap_b),  1);
        step();
        chk("b_start3", 32'(start_b), 1);
        chk("b_pend3",  32'(pend_b),  0);
        chk("b_wb3",    32'(wb_b),    0);
        step();
        pulse(0, 0, 1, 0);
        chk("b_empty_valid", 32'(valid_b), 0);
        chk("b_empty_start", 32'(start_b), 0);
        step();
        chk("b_empty_start2", 32'(start_b), 0);
        chk("b_empty_drop",   32'(drop_b),  3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
